// File: rtl/control_in_buffer.sv
//------------------------------------------------------------------------------
// Module   : control_in_buffer
// Brief    : Parametrised valid/ready control-word FIFO with flush, selectable
//            full handling (back-pressure or drop) and drop statistics.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_in_buffer #(
    parameter int CTRL_W       = 32,
    parameter int DEPTH        = 4,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       clr_stat_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = $clog2(DEPTH+1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [CTRL_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_write;
    logic w_read;
    logic w_drop;
    logic [c_CW-1:0] w_count_nxt;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // in_ready depends only on registered occupancy, never on out_ready.
    generate
        if (DROP_ON_FULL != 0) begin : g_mode_drop
            assign in_ready = 1'b1;
        end else begin : g_mode_backpressure
            assign in_ready = !w_full;
        end
    endgenerate

    assign w_push  = in_valid && in_ready;
    assign w_pop   = !w_empty && out_ready;
    assign w_write = w_push && (!w_full || w_pop) && !flush_i;
    assign w_read  = w_pop && !flush_i;
    assign w_drop  = w_push && w_full && !w_pop && !flush_i;

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_write, w_read})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= in_ctrl;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_read) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // Clear has priority over a drop landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr_stat_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_ctrl  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_control_in_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_control_in_buffer
// Brief    : Directed bench driving a back-pressure and a drop-mode instance
//            with shared stimulus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_in_buffer;

    localparam int CTRL_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              clr_stat_i;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_ready;

    logic              in_ready0, out_valid0, full0, empty0, overflow0;
    logic [CTRL_W-1:0] out_ctrl0;
    logic [CW-1:0]     count0;
    logic [CNT_W-1:0]  drop0;
    logic              in_ready1, out_valid1, full1, empty1, overflow1;
    logic [CTRL_W-1:0] out_ctrl1;
    logic [CW-1:0]     count1;
    logic [CNT_W-1:0]  drop1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q [4];
    logic [31:0] wrap_q [7];

    always #5 clk = ~clk;

    control_in_buffer #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .DROP_ON_FULL(0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .clr_stat_i(clr_stat_i),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .count(count0), .full(full0), .empty(empty0), .overflow(overflow0), .drop_cnt(drop0)
    );

    control_in_buffer #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .DROP_ON_FULL(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .clr_stat_i(clr_stat_i),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .count(count1), .full(full1), .empty(empty1), .overflow(overflow1), .drop_cnt(drop1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " count0"},   32'(count0),     32'd0);
        chk({tag, " empty0"},   32'(empty0),     32'd1);
        chk({tag, " full0"},    32'(full0),      32'd0);
        chk({tag, " valid0"},   32'(out_valid0), 32'd0);
        chk({tag, " ctrl0"},    out_ctrl0,       32'd0);
        chk({tag, " ready0"},   32'(in_ready0),  32'd1);
        chk({tag, " ovf0"},     32'(overflow0),  32'd0);
        chk({tag, " drop0"},    32'(drop0),      32'd0);
        chk({tag, " count1"},   32'(count1),     32'd0);
        chk({tag, " valid1"},   32'(out_valid1), 32'd0);
        chk({tag, " ctrl1"},    out_ctrl1,       32'd0);
        chk({tag, " ready1"},   32'(in_ready1),  32'd1);
        chk({tag, " ovf1"},     32'(overflow1),  32'd0);
        chk({tag, " drop1"},    32'(drop1),      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        flush_i    = 1'b0;
        clr_stat_i = 1'b0;
        in_valid   = 1'b0;
        in_ctrl    = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Fill both instances with 0x11..0x44, consumer stalled.
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_ctrl = 32'(i * 'h11);
            tick();
        end
        chk("fill count0", 32'(count0), 32'd4);
        chk("fill full0",  32'(full0),  32'd1);
        chk("fill ready0", 32'(in_ready0), 32'd0);
        chk("fill ready1", 32'(in_ready1), 32'd1);
        chk("fill head1",  out_ctrl1, 32'h11);

        // Three more words while full: drop mode counts them.
        for (int i = 0; i < 3; i++) begin
            in_ctrl = 32'hAA + 32'(i);
            tick();
        end
        chk("drop count1", 32'(count1),    32'd4);
        chk("drop head1",  out_ctrl1,      32'h11);
        chk("drop ovf1",   32'(overflow1), 32'd1);
        chk("drop cnt1",   32'(drop1),     32'd3);
        chk("drop ovf0",   32'(overflow0), 32'd0);
        chk("drop cnt0",   32'(drop0),     32'd0);

        in_valid   = 1'b0;
        clr_stat_i = 1'b1;
        tick();
        clr_stat_i = 1'b0;
        chk("clr ovf1", 32'(overflow1), 32'd0);
        chk("clr cnt1", 32'(drop1),     32'd0);

        // Drop and clear in the same cycle: clear wins.
        in_valid   = 1'b1;
        in_ctrl    = 32'hDD;
        clr_stat_i = 1'b1;
        tick();
        clr_stat_i = 1'b0;
        in_valid   = 1'b0;
        chk("clrwin ovf1", 32'(overflow1), 32'd0);
        chk("clrwin cnt1", 32'(drop1),     32'd0);

        // Full plus push plus pop: drop mode writes, back-pressure mode only pops.
        in_valid  = 1'b1;
        in_ctrl   = 32'h55;
        out_ready = 1'b1;
        chk("fpp head0", out_ctrl0, 32'h11);
        chk("fpp head1", out_ctrl1, 32'h11);
        tick();
        in_valid = 1'b0;
        chk("fpp count1", 32'(count1), 32'd4);
        chk("fpp count0", 32'(count0), 32'd3);

        exp_q[0] = 32'h22;
        exp_q[1] = 32'h33;
        exp_q[2] = 32'h44;
        exp_q[3] = 32'h55;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d ctrl1", i), out_ctrl1, exp_q[i]);
            chk($sformatf("drain%0d valid1", i), 32'(out_valid1), 32'd1);
            if (i < 3) begin
                chk($sformatf("drain%0d ctrl0", i), out_ctrl0, exp_q[i]);
            end else begin
                chk($sformatf("drain%0d valid0", i), 32'(out_valid0), 32'd0);
            end
            tick();
        end
        chk("drain empty0", 32'(empty0), 32'd1);
        chk("drain empty1", 32'(empty1), 32'd1);

        // Latency: push into empty buffer, visible next cycle, no bypass.
        in_valid = 1'b1;
        in_ctrl  = 32'hA5;
        chk("lat nobypass0", 32'(out_valid0), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("lat valid0", 32'(out_valid0), 32'd1);
        chk("lat ctrl0",  out_ctrl0,       32'hA5);
        chk("lat ctrl1",  out_ctrl1,       32'hA5);
        tick();
        chk("lat empty0", 32'(empty0), 32'd1);
        chk("lat empty1", 32'(empty1), 32'd1);

        // Flush with three entries and a simultaneous push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_ctrl = 32'(i);
            tick();
        end
        chk("pre-flush count0", 32'(count0), 32'd3);
        in_ctrl = 32'h77;
        flush_i = 1'b1;
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        chk("flush count0", 32'(count0),     32'd0);
        chk("flush valid0", 32'(out_valid0), 32'd0);
        chk("flush count1", 32'(count1),     32'd0);
        chk("flush drop1",  32'(drop1),      32'd0);
        in_valid = 1'b1;
        in_ctrl  = 32'h88;
        tick();
        in_valid  = 1'b0;
        chk("postflush ctrl0", out_ctrl0,    32'h88);
        chk("postflush count0", 32'(count0), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset with two entries held.
        in_valid = 1'b1;
        in_ctrl  = 32'h01;
        tick();
        in_ctrl  = 32'h02;
        tick();
        in_valid = 1'b0;
        chk("prerst count0", 32'(count0), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset("async");
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_ctrl  = 32'h99;
        tick();
        chk("rst99 ctrl0", out_ctrl0, 32'h99);
        chk("rst99 valid0", 32'(out_valid0), 32'd1);

        // Six concurrent push/pop cycles take both pointers past the wrap.
        wrap_q[0] = 32'h99;
        for (int i = 1; i < 7; i++) begin
            wrap_q[i] = 32'hC0 + 32'(i);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_ctrl = wrap_q[i+1];
            chk($sformatf("wrap%0d ctrl0", i), out_ctrl0, wrap_q[i]);
            chk($sformatf("wrap%0d ctrl1", i), out_ctrl1, wrap_q[i]);
            tick();
            chk($sformatf("wrap%0d count0", i), 32'(count0), 32'd1);
        end
        in_valid = 1'b0;
        chk("wrap last ctrl0", out_ctrl0, wrap_q[6]);
        tick();
        out_ready = 1'b0;
        chk("wrap empty0", 32'(empty0), 32'd1);
        chk("wrap empty1", 32'(empty1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
